// File: rtl/recibidor_ctrl.sv
// recibidor_ctrl: serial-receiver link controller with COM lock, error-window loss of lock, width select and word framing
module recibidor_ctrl #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 4,
  parameter int ERR_WINDOW = 16
) (
  input  logic       clkRx,
  input  logic       rst,
  input  logic       enb,
  input  logic       symValid,
  input  logic [7:0] symData,
  input  logic       k_out,
  input  logic       error_probable,
  input  logic [1:0] widthReq,
  output logic       rxEnb,
  output logic [1:0] dataS,
  output logic       locked,
  output logic       lockLost,
  output logic       wordValid,
  output logic [3:0] errCount
);
  typedef enum logic [1:0] {IDLE, HUNT, ALIGN, LOCKED} state_t;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] LE = 4'(ERR_LIMIT);
  localparam logic [7:0] LW = 8'(ERR_WINDOW);
  state_t     r_state;
  logic [3:0] r_com;
  logic [7:0] r_win;
  logic [2:0] r_word;
  logic       w_com, w_err, w_data, w_lim, w_wend, w_wdone;
  logic [3:0] w_errn, w_comn;
  logic [7:0] w_winn;
  logic [2:0] w_wlen, w_wordn;
  always_comb begin
    w_com   = symValid & k_out & ~error_probable & (symData == 8'hBC);
    w_err   = symValid & error_probable;
    w_data  = symValid & ~k_out & ~error_probable;
    w_comn  = r_com + 4'd1;
    w_errn  = (errCount == 4'd15) ? errCount : errCount + 4'd1;
    w_lim   = w_err & (w_errn >= LE);
    w_winn  = r_win + 8'd1;
    w_wend  = (w_winn == LW);
    w_wlen  = (dataS == 2'b00) ? 3'd1 : (dataS == 2'b01) ? 3'd2 : 3'd4;
    w_wordn = r_word + 3'd1;
    w_wdone = (w_wordn == w_wlen);
  end
  always_ff @(posedge clkRx or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_com     <= 4'd0;
      r_win     <= 8'd0;
      r_word    <= 3'd0;
      rxEnb     <= 1'b0;
      dataS     <= 2'b00;
      locked    <= 1'b0;
      lockLost  <= 1'b0;
      wordValid <= 1'b0;
      errCount  <= 4'd0;
    end else begin
      lockLost  <= 1'b0;
      wordValid <= 1'b0;
      if (!enb) begin
        lockLost <= (r_state == LOCKED);
        r_state  <= IDLE;
        rxEnb    <= 1'b0;
        locked   <= 1'b0;
        r_com    <= 4'd0;
        r_win    <= 8'd0;
        r_word   <= 3'd0;
        errCount <= 4'd0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= HUNT;
            rxEnb   <= 1'b1;
          end
          HUNT: if (w_com) begin
            r_state <= ALIGN;
            r_com   <= 4'd1;
          end
          ALIGN: begin
            if (w_err) begin
              r_state <= HUNT;
              r_com   <= 4'd0;
            end else if (w_com) begin
              r_com <= (w_comn == LC) ? 4'd0 : w_comn;
              if (w_comn == LC) begin
                r_state <= LOCKED;
                locked  <= 1'b1;
              end
            end
          end
          LOCKED: if (symValid) begin
            if (w_lim) begin
              r_state  <= HUNT;
              locked   <= 1'b0;
              lockLost <= 1'b1;
              r_win    <= 8'd0;
              errCount <= 4'd0;
              r_word   <= 3'd0;
            end else begin
              // the limit check above already ran, so the window end may clear the errors
              r_win    <= w_wend ? 8'd0 : w_winn;
              errCount <= w_wend ? 4'd0 : (w_err ? w_errn : errCount);
              if (w_com && widthReq != 2'b11) dataS <= widthReq;
              r_word    <= (w_data && !w_wdone) ? w_wordn : 3'd0;
              wordValid <= w_data & w_wdone;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_recibidor_ctrl.sv
// tb_recibidor_ctrl: directed test-plan scenarios plus random symbol streams checked against a spec-level model
module tb_recibidor_ctrl;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_LIMIT  = 4;
  localparam int ERR_WINDOW = 16;
  logic       clkRx = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic       symValid = 1'b0;
  logic [7:0] symData = 8'h00;
  logic       k_out = 1'b0;
  logic       error_probable = 1'b0;
  logic [1:0] widthReq = 2'b00;
  logic       rxEnb, locked, lockLost, wordValid;
  logic [1:0] dataS;
  logic [3:0] errCount;
  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  recibidor_ctrl #(.LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .ERR_WINDOW(ERR_WINDOW)) dut (
    .clkRx(clkRx), .rst(rst), .enb(enb), .symValid(symValid), .symData(symData),
    .k_out(k_out), .error_probable(error_probable), .widthReq(widthReq),
    .rxEnb(rxEnb), .dataS(dataS), .locked(locked), .lockLost(lockLost),
    .wordValid(wordValid), .errCount(errCount)
  );
  always #5 clkRx = ~clkRx;
  int       m_st;
  int       m_com, m_win, m_err, m_word;
  bit [1:0] m_ds;
  bit       m_ll, m_wv;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void m_reset();
    m_st = 0; m_com = 0; m_win = 0; m_err = 0; m_word = 0;
    m_ds = 2'b00; m_ll = 0; m_wv = 0;
  endfunction
  function automatic void m_clear();
    m_com = 0; m_win = 0; m_err = 0; m_word = 0;
  endfunction
  function automatic void m_step(bit en, bit v, bit [7:0] d, bit k, bit e, bit [1:0] w);
    bit com;
    com  = v && k && !e && d == 8'hBC;
    m_ll = 0;
    m_wv = 0;
    if (!en) begin
      m_ll = (m_st == 3);
      m_st = 0;
      m_clear();
    end else if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (com) begin m_st = 2; m_com = 1; end
    end else if (m_st == 2) begin
      if (v && e) begin m_st = 1; m_com = 0; end
      else if (com) begin
        m_com++;
        if (m_com == LOCK_COUNT) m_st = 3;
      end
    end else if (v) begin
      m_win++;
      if (e) m_err = (m_err < 15) ? m_err + 1 : 15;
      if (e && m_err >= ERR_LIMIT) begin
        m_st = 1;
        m_ll = 1;
        m_clear();
      end else begin
        if (m_win == ERR_WINDOW) begin m_win = 0; m_err = 0; end
        if (com && w != 2'b11) m_ds = w;
        if (!k && !e) begin
          m_word++;
          if (m_word == (1 << m_ds)) begin m_wv = 1; m_word = 0; end
        end else m_word = 0;
      end
    end
  endfunction
  task automatic cmp_all();
    chk("rxEnb", rxEnb, m_st != 0);
    chk("locked", locked, m_st == 3);
    chk("lockLost", lockLost, m_ll);
    chk("wordValid", wordValid, m_wv);
    chk("dataS", dataS, m_ds);
    chk("errCount", errCount, 8'(m_err));
  endtask
  task automatic tick(input bit en, input bit v, input bit [7:0] d, input bit k, input bit e, input bit [1:0] w);
    enb = en; symValid = v; symData = d; k_out = k; error_probable = e; widthReq = w;
    @(posedge clkRx);
    m_step(en, v, d, k, e, w);
    @(negedge clkRx);
    cmp_all();
    if (wordValid) wv_cnt++;
  endtask
  task automatic com(input bit [1:0] w);
    tick(1, 1, 8'hBC, 1, 0, w);
  endtask
  task automatic dat(input bit [1:0] w);
    tick(1, 1, 8'($urandom), 0, 0, w);
  endtask
  task automatic errsym();
    tick(1, 1, 8'($urandom), 0, 1, 2'b00);
  endtask
  task automatic rst_pulse();
    #2 rst = 1'b0;
    #1 m_reset();
    cmp_all();
    @(negedge clkRx) rst = 1'b1;
    cmp_all();
  endtask
  bit       en, v, k, e;
  bit [7:0] d;
  bit [1:0] w;
  int       t;
  initial begin
    m_reset();
    #3 cmp_all();
    @(negedge clkRx) rst = 1'b1;
    tick(1, 0, 8'h00, 0, 0, 2'b00);
    chk("rxEnb_rise", rxEnb, 1);
    repeat (3) com(2'b00);
    chk("locked_3com", locked, 0);
    com(2'b00);
    chk("locked_4com", locked, 1);
    chk("dataS_lock", dataS, 2'b00);
    tick(0, 0, 8'h00, 0, 0, 2'b00);
    chk("lockLost_enb", lockLost, 1);
    tick(1, 0, 8'h00, 0, 0, 2'b00);
    repeat (3) com(2'b00);
    errsym();
    chk("align_err", locked, 0);
    repeat (3) com(2'b00);
    chk("relock_3", locked, 0);
    com(2'b00);
    chk("relock_4", locked, 1);
    repeat (3) errsym();
    chk("err3", errCount, 3);
    errsym();
    chk("loss_pulse", lockLost, 1);
    chk("loss_locked", locked, 0);
    chk("loss_errcnt", errCount, 0);
    tick(1, 0, 8'h00, 0, 0, 2'b00);
    chk("loss_once", lockLost, 0);
    repeat (4) com(2'b00);
    for (int win = 0; win < 3; win++) begin
      for (int i = 0; i < ERR_WINDOW; i++)
        if (i == 0 || i == 5 || i == 10) errsym(); else dat(2'b00);
      chk("win_keep", locked, 1);
      chk("win_clear", errCount, 0);
    end
    repeat (3) dat(2'b10);
    chk("ds_hold", dataS, 2'b00);
    com(2'b10);
    chk("ds_32", dataS, 2'b10);
    wv_cnt = 0;
    repeat (8) dat(2'b10);
    chk("w32_pulses", 8'(wv_cnt), 2);
    com(2'b11);
    chk("ds_rsvd", dataS, 2'b10);
    com(2'b01);
    wv_cnt = 0;
    dat(2'b01);
    com(2'b01);
    dat(2'b01);
    chk("w16_nopulse", 8'(wv_cnt), 0);
    dat(2'b01);
    chk("w16_pulses", 8'(wv_cnt), 1);
    chk("w16_last", wordValid, 1);
    tick(0, 0, 8'h00, 0, 0, 2'b00);
    chk("enb_off_ll", lockLost, 1);
    chk("enb_off_rx", rxEnb, 0);
    tick(1, 0, 8'h00, 0, 0, 2'b00);
    repeat (4) com(2'b01);
    dat(2'b01);
    rst_pulse();
    chk("rst_ds", dataS, 2'b00);
    chk("rst_locked", locked, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 511) == 0) rst_pulse();
      else begin
        en = ($urandom_range(0, 63) != 0);
        v  = ($urandom_range(0, 9) < 7);
        t  = $urandom_range(0, 19);
        k  = (t < 7);
        d  = (t < 5) ? 8'hBC : (t < 7) ? 8'h3C : 8'($urandom);
        e  = ($urandom_range(0, 19) == 0);
        w  = 2'($urandom);
        tick(en, v, d, k, e, w);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/recibidor_ctrl.md
# recibidor_ctrl

Link-receive controller that sequences the PCIe-style serial receiver block. It gates the receiver's enable and acquires symbol lock from decoded COM (K28.5) symbols. It monitors `error_probable` to drop lock, and selects the output width `dataS` only at safe COM boundaries. It also frames decoded data symbols into 8/16/32-bit words. It sits between the receiver's decoded-symbol outputs and the link-layer consumer, in the `clkRx` domain.

## Interface
- `LOCK_COUNT`, 4: error-free COM symbols required to declare lock (2..15).
- `ERR_LIMIT`, 4: errors within one window that force loss of lock (1..15).
- `ERR_WINDOW`, 16: window length in valid symbols (2..255).

- `clkRx` in 1: receive clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enb` in 1: controller enable.
- `symValid` in 1: one-cycle strobe from the receiver, one per decoded symbol.
- `symData` in 8: decoded symbol, qualified by `symValid`.
- `k_out` in 1: symbol is a K code, qualified by `symValid`.
- `error_probable` in 1: decode/disparity error on the symbol, qualified by `symValid`.
- `widthReq` in 2: requested width. 00 = 8, 01 = 16, 10 = 32, 11 = reserved and ignored.
- `rxEnb` out 1: enable driven to the receiver.
- `dataS` out 2: width select driven to the receiver.
- `locked` out 1: high in LOCKED.
- `lockLost` out 1: one-cycle pulse on LOCKED→HUNT.
- `wordValid` out 1: one-cycle pulse when a word of the current width completes.
- `errCount` out 4: errors in the current window, saturating at 15.

## Operation
- COM is `symValid & k_out & ~error_probable & symData==8'hBC`. An errored symbol is never a COM.
- States: IDLE, HUNT, ALIGN, LOCKED.
- IDLE
  - `rxEnb=0`; `comCnt`, `winCnt` and `errCount` are held at 0.
  - `enb=1` → HUNT.
- HUNT
  - `rxEnb=1`.
  - COM → ALIGN with `comCnt=1`.
  - Other symbols are ignored.
- ALIGN
  - COM increments `comCnt`; when the count reaches `LOCK_COUNT` → LOCKED.
  - Valid non-errored non-COM symbols leave `comCnt` unchanged.
  - Any `symValid & error_probable` → HUNT with `comCnt=0`.
- LOCKED
  - Error window:
    - `winCnt` increments on every `symValid`.
    - `errCount` increments on `symValid & error_probable`.
    - If `errCount` would reach `ERR_LIMIT` → HUNT, `lockLost` pulses, and `winCnt`, `errCount` and the word counter clear.
    - Otherwise, on the symbol that makes `winCnt==ERR_WINDOW`, `winCnt` and `errCount` clear to 0. The error check is done before the clear.
  - Width update:
    - On a COM in LOCKED with `widthReq!=11`, `dataS<=widthReq` and the word counter clears.
    - `dataS` changes at no other time, and holds its value outside LOCKED.
  - Word framing:
    - A data symbol is `symValid & ~k_out & ~error_probable`.
    - The word counter counts data symbols; a word is 1, 2 or 4 symbols for `dataS` 00, 01, 10.
    - When the count completes a word, `wordValid` pulses and the counter clears.
    - Any K symbol or errored symbol clears the counter without pulsing `wordValid`.
- `enb=0` in any state → IDLE on the next edge. Counters clear; `dataS` is held; `lockLost` pulses if the controller was in LOCKED.

## Timing
- Reset (`rst=0`, asynchronous) forces:
  - state IDLE, `rxEnb=0`, `dataS=00`, `locked=0`, `lockLost=0`, `wordValid=0`, `errCount=0`, all internal counters 0.
- All outputs are registered and update on the edge at which the qualifying `symValid` is sampled; they are visible the following cycle.
- `rxEnb` rises one cycle after `enb` is sampled high in IDLE.
- `locked` rises on the edge that samples the `LOCK_COUNT`-th COM. It falls on the edge that samples the limit-reaching error, or on the edge that samples `enb=0`.
- `symValid` may be asserted on consecutive cycles; every strobe is processed and none is dropped.
- Simultaneous events:
  - Error and window end on the same symbol: the limit check is done first.
  - COM with a width change on the last symbol of a word: the counter clears and there is no `wordValid`, since a K symbol is never data.
  - `enb=0` takes priority over every other transition.
- Reset mid-operation aborts immediately. No partial word is reported.

## Test plan
- Reset, `enb=1`, four back-to-back COMs with no errors → `rxEnb` high one cycle after `enb`; `locked=1` after the 4th COM; `dataS=00`.
- ALIGN with `comCnt=3`, one symbol with `error_probable=1` → state HUNT, `locked` stays 0. A fresh run of four COMs is then needed to lock.
- LOCKED, 4 errors within 16 symbols → `lockLost` pulses once, `locked=0`, `errCount=0`. Variant: 3 errors per window repeated across 3 windows → lock is kept and `errCount` returns to 0 at each window end.
- LOCKED with `widthReq=10` changed mid-stream → `dataS` stays 00 until the next COM, then becomes 10. After that, 8 data symbols produce exactly 2 `wordValid` pulses. `widthReq=11` at a COM → `dataS` is unchanged.
- `dataS=01`, data, K28.5, data, data → exactly one `wordValid` pulse, issued after the final data symbol.
- `enb` deasserted while LOCKED, then `rst` pulsed low mid-word → `lockLost` pulse followed by IDLE; after reset all outputs are 0 and `dataS=00`.
